// File: rtl/wb_write_queue_pkg.sv
// Shared widths and entry type for the register-file write queue.
// Default geometry lives here; the modules take it as parameters.
package wb_write_queue_pkg;
  localparam int REG_AW        = 5;
  localparam int DATA_W        = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_AW    = 2;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] dr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// Bus bundle between the result producers/decode and the write queue.
// The slave modport is the queue's view of the bundle.
interface wb_write_queue_if;
  import wb_write_queue_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_dr;
  logic [DATA_W-1:0] alu_data;
  logic              lu_valid;
  logic [REG_AW-1:0] lu_dr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              stall;
  logic [REG_AW-1:0] q_reg;
  logic              q_pending;
  logic              RegW;
  logic [REG_AW-1:0] DR;
  logic [DATA_W-1:0] Reg_In;

  modport master (
    output alu_valid, alu_dr, alu_data, lu_valid, lu_dr, lu_data, q_reg,
    input  lu_ready, stall, q_pending, RegW, DR, Reg_In
  );

  modport slave (
    input  alu_valid, alu_dr, alu_data, lu_valid, lu_dr, lu_data, q_reg,
    output lu_ready, stall, q_pending, RegW, DR, Reg_In
  );
endinterface

// File: rtl/wb_fifo2w1r.sv
// Circular buffer with two write ports (wr0 is older) and one read port.
// Exports per-slot occupancy and destination so the top can answer hazard queries.
module wb_fifo2w1r
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         wr0_en,
  input  wb_entry_t                    wr0_entry,
  input  logic                         wr1_en,
  input  wb_entry_t                    wr1_entry,
  input  logic                         rd_en,
  output wb_entry_t                    rd_entry,
  output logic [AW:0]                  count,
  output logic [DEPTH-1:0]             slot_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] slot_dr
);
  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     wr1_ptr;

  // The second write lands right behind the first when both fire.
  assign wr1_ptr  = wr_ptr + AW'(wr0_en);
  assign rd_entry = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + (AW+1)'(wr0_en) + (AW+1)'(wr1_en) - (AW+1)'(rd_en);
    end
  end

  // NOTE: storage is deliberately not reset; occupancy comes only from the pointers and count.
  always_ff @(posedge CLK) begin
    if (wr0_en) mem[wr_ptr]  <= wr0_entry;
    if (wr1_en) mem[wr1_ptr] <= wr1_entry;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [AW-1:0] offs;
    assign offs          = AW'(i) - rd_ptr;
    assign slot_valid[i] = ({1'b0, offs} < count);
    assign slot_dr[i]    = mem[i].dr;
  end
endmodule

// File: rtl/wb_write_queue.sv
// Register-file write-port arbiter: merges ALU and LU results into an in-order
// queue and retires one register write per cycle through registered outputs.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input logic               CLK,
  input logic               RST,
  wb_write_queue_if.slave   bus
);
  logic [AW:0]                  count;
  logic [AW:0]                  free_now;
  logic [AW:0]                  free_after_alu;
  logic [DEPTH-1:0]             slot_valid;
  logic [DEPTH-1:0][REG_AW-1:0] slot_dr;
  wb_entry_t                    head;
  logic                         alu_push;
  logic                         lu_ready;
  logic                         lu_push;
  logic                         pop;
  logic                         ovf_hit;
  logic                         q_hit;
  logic                         ovf_err;

  assign free_now = (AW+1)'(DEPTH) - count;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_push       = 1'b0;
    free_after_alu = free_now;
    lu_ready       = 1'b0;
    lu_push        = 1'b0;
    ovf_hit        = 1'b0;
    // $zero results complete their handshake but never occupy a slot.
    alu_push       = bus.alu_valid && (bus.alu_dr != ZERO_REG) && (free_now != '0);
    ovf_hit        = bus.alu_valid && (free_now == '0);
    free_after_alu = free_now - (AW+1)'(alu_push);
    lu_ready       = (free_after_alu != '0);
    lu_push        = bus.lu_valid && lu_ready && (bus.lu_dr != ZERO_REG);
  end

  // Entries already popped onto DR are outside the valid window and thus excluded.
  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (slot_dr[i] == bus.q_reg)) q_hit = 1'b1;
    end
  end

  assign pop           = (count != '0);
  assign bus.lu_ready  = lu_ready;
  assign bus.stall     = (free_now < (AW+1)'(2));
  assign bus.q_pending = q_hit && (bus.q_reg != ZERO_REG);

  wb_fifo2w1r #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .wr0_en     (alu_push),
    .wr0_entry  ('{dr: bus.alu_dr, data: bus.alu_data}),
    .wr1_en     (lu_push),
    .wr1_entry  ('{dr: bus.lu_dr, data: bus.lu_data}),
    .rd_en      (pop),
    .rd_entry   (head),
    .count      (count),
    .slot_valid (slot_valid),
    .slot_dr    (slot_dr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.RegW   <= 1'b0;
      bus.DR     <= '0;
      bus.Reg_In <= '0;
      ovf_err    <= 1'b0;
    end else begin
      bus.RegW <= pop;
      if (pop) begin
        bus.DR     <= head.dr;
        bus.Reg_In <= head.data;
      end
      if (ovf_hit) ovf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  wb_write_queue_if bus();

  wb_write_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes plus the expected output registers.
  wb_entry_t   mq[$];
  logic        e_regw = 1'b0;
  logic [4:0]  e_dr   = '0;
  logic [31:0] e_data = '0;
  logic        e_ovf  = 1'b0;
  int          m_sz;
  int          m_alu;

  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      e_regw = 1'b0;
      e_dr   = '0;
      e_data = '0;
      e_ovf  = 1'b0;
    end else begin
      m_sz = mq.size();
      if (m_sz > 0) begin
        e_regw = 1'b1;
        e_dr   = mq[0].dr;
        e_data = mq[0].data;
        void'(mq.pop_front());
      end else begin
        e_regw = 1'b0;
      end
      if (bus.alu_valid && m_sz == DEPTH) e_ovf = 1'b1;
      m_alu = (bus.alu_valid && bus.alu_dr != 0 && m_sz < DEPTH) ? 1 : 0;
      if (m_alu == 1) mq.push_back('{dr: bus.alu_dr, data: bus.alu_data});
      if (bus.lu_valid && (DEPTH - m_sz - m_alu) >= 1 && bus.lu_dr != 0)
        mq.push_back('{dr: bus.lu_dr, data: bus.lu_data});
    end
  end

  int   c_sz;
  int   c_alu;
  logic c_qp;

  always @(negedge CLK) begin
    if (chk_en) begin
      c_sz  = mq.size();
      c_alu = (bus.alu_valid && bus.alu_dr != 0 && c_sz < DEPTH) ? 1 : 0;
      c_qp  = 1'b0;
      foreach (mq[i]) if (bus.q_reg != 0 && mq[i].dr == bus.q_reg) c_qp = 1'b1;
      check("m_regw",   bus.RegW,      e_regw);
      check("m_dr",     bus.DR,        e_dr);
      check("m_reg_in", bus.Reg_In,    e_data);
      check("m_stall",  bus.stall,     (DEPTH - c_sz) < 2);
      check("m_ready",  bus.lu_ready,  (DEPTH - c_sz - c_alu) >= 1);
      check("m_qpend",  bus.q_pending, c_qp);
      check("m_ovf",    dut.ovf_err,   e_ovf);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    chk_en = 1'b1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] dr, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_dr    = dr;
    bus.alu_data  = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] dr, input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_dr    = dr;
    bus.lu_data  = d;
  endtask

  initial begin
    RST       = 1'b1;
    bus.q_reg = '0;
    set_alu(1'b1, 5'd1, 32'h1);
    set_lu(1'b0, '0, '0);

    // Reset held two cycles with alu_valid high
    step();
    step();
    check("rst_regw",  bus.RegW,     1'b0);
    check("rst_dr",    bus.DR,       5'd0);
    check("rst_regin", bus.Reg_In,   32'h0);
    check("rst_ready", bus.lu_ready, 1'b1);
    check("rst_stall", bus.stall,    1'b0);
    RST = 1'b0;

    // Single ALU write: visible one edge after the push edge
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_alu(1'b0, '0, '0);
    step();
    check("single_regw",  bus.RegW,   1'b1);
    check("single_dr",    bus.DR,     5'd5);
    check("single_regin", bus.Reg_In, 32'hDEADBEEF);
    step();
    check("single_regw_off", bus.RegW, 1'b0);
    check("single_dr_hold",  bus.DR,   5'd5);

    // Dual push: ALU is older than LU
    set_alu(1'b1, 5'd3, 32'h11);
    set_lu(1'b1, 5'd4, 32'h22);
    bus.q_reg = 5'd4;
    step();
    set_alu(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    step();
    check("dual_dr0",   bus.DR,        5'd3);
    check("dual_d0",    bus.Reg_In,    32'h11);
    check("dual_qpend", bus.q_pending, 1'b1);
    step();
    check("dual_dr1",     bus.DR,        5'd4);
    check("dual_d1",      bus.Reg_In,    32'h22);
    check("dual_qp_gone", bus.q_pending, 1'b0);
    step();
    check("dual_idle", bus.RegW, 1'b0);

    // Fill: stall once free < 2, LU refused when ALU takes the last slot
    set_alu(1'b1, 5'd6, 32'h60);
    set_lu(1'b1, 5'd7, 32'h70);
    step();
    check("fill_stall0", bus.stall, 1'b0);
    set_alu(1'b1, 5'd8, 32'h80);
    set_lu(1'b1, 5'd9, 32'h90);
    step();
    check("fill_stall1", bus.stall, 1'b1);
    check("fill_dr6",    bus.DR,    5'd6);
    set_alu(1'b1, 5'd10, 32'hA0);
    set_lu(1'b1, 5'd11, 32'hB0);
    #1;
    check("fill_ready_full", bus.lu_ready, 1'b0);
    step();
    check("fill_dr7", bus.DR, 5'd7);
    set_alu(1'b0, '0, '0);
    #1;
    check("fill_ready_back", bus.lu_ready, 1'b1);
    step();
    set_lu(1'b0, '0, '0);
    check("fill_dr8", bus.DR, 5'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fill_order", bus.DR, 5'(9 + i));
      check("fill_data",  bus.Reg_In, 32'h90 + 32'(i) * 32'h10);
    end
    step();
    check("fill_drained", bus.RegW,    1'b0);
    check("fill_no_ovf",  dut.ovf_err, 1'b0);

    // $zero filter
    set_alu(1'b1, 5'd0, 32'h55);
    set_lu(1'b1, 5'd0, 32'h66);
    bus.q_reg = 5'd0;
    #1;
    check("zero_ready", bus.lu_ready,  1'b1);
    check("zero_qpend", bus.q_pending, 1'b0);
    step();
    set_alu(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    check("zero_count", dut.count, 3'd0);
    check("zero_stall", bus.stall, 1'b0);
    step();
    check("zero_regw",  bus.RegW,   1'b0);
    check("zero_regin", bus.Reg_In, 32'hB0);

    // Mid-operation reset discards queued entries
    set_alu(1'b1, 5'd12, 32'hC0);
    set_lu(1'b1, 5'd13, 32'hD0);
    step();
    set_alu(1'b1, 5'd14, 32'hE0);
    set_lu(1'b1, 5'd15, 32'hF0);
    step();
    check("mid_dr12", bus.DR,    5'd12);
    check("mid_cnt3", dut.count, 3'd3);
    set_alu(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    bus.q_reg = 5'd15;
    RST = 1'b1;
    step();
    check("mid_regw",  bus.RegW,      1'b0);
    check("mid_dr",    bus.DR,        5'd0);
    check("mid_regin", bus.Reg_In,    32'h0);
    check("mid_qpend", bus.q_pending, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_stale", bus.RegW, 1'b0);
    end

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
